// File: rtl/edge_pulse_gen_pkg.sv
// Shared types and helpers for the edge pulse generator. The state encoding
// comes from pulse_defs.vh.
`include "pulse_defs.vh"

package edge_pulse_gen_pkg;

    typedef enum logic [1:0] {
        S_IDLE = `ST_IDLE,
        S_HIGH = `ST_HIGH,
        S_LOW  = `ST_LOW
    } state_t;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/edge_pulse_gen_timer.sv
// Phase timer: it loads at phase entry, then counts down to zero and holds there.
// done_o marks the last cycle of the current phase.
module pulse_timer #(
    parameter int TW = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load_i,
    input  logic [TW-1:0] load_val_i,
    output logic          done_o
);

    logic [TW-1:0] count_q;
    logic [TW-1:0] count_d;

    // A count at zero holds at zero, so the timer never wraps.
    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (count_q != '0) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign done_o = (count_q == '0);

endmodule

// File: rtl/pulse_defs.vh
// State codes for the edge-pulse FSM. Other pulse-train blocks and benches include
// this header so that everyone uses the same encoding.
`ifndef PULSE_DEFS_VH
`define PULSE_DEFS_VH
`define ST_IDLE 2'd0
`define ST_HIGH 2'd1
`define ST_LOW  2'd2
`endif

// File: rtl/edge_pulse_gen.sv
// Converts single-cycle trigger requests into rectangular pulses on y_out.
// Requests that arrive while a pulse is in flight are queued in a saturating counter.
module edge_pulse_gen
    import edge_pulse_gen_pkg::*;
#(
    parameter int HIGH_CYCLES = 3,
    parameter int LOW_CYCLES  = 2,
    parameter int PEND_W      = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              trig,
    output logic              y_out,
    output logic              busy,
    output logic [PEND_W-1:0] pending,
    output logic              overflow
);

    if (HIGH_CYCLES < 1) begin : g_bad_high
        $error("edge_pulse_gen: HIGH_CYCLES must be >= 1");
    end
    if (LOW_CYCLES < 1) begin : g_bad_low
        $error("edge_pulse_gen: LOW_CYCLES must be >= 1");
    end
    if (PEND_W < 1) begin : g_bad_pend
        $error("edge_pulse_gen: PEND_W must be >= 1");
    end

    localparam int TW = $clog2(max2(HIGH_CYCLES, LOW_CYCLES)) + 1;
    localparam logic [TW-1:0] HI_LOAD = TW'(HIGH_CYCLES - 1);
    localparam logic [TW-1:0] LO_LOAD = TW'(LOW_CYCLES - 1);
    localparam logic [PEND_W-1:0] PEND_MAX = {PEND_W{1'b1}};

    state_t            state_q, state_d;
    logic              y_out_q, busy_q, overflow_q;
    logic [PEND_W-1:0] pending_q, pending_d;
    logic              tmr_load, tmr_done, start, drop, inc, dec;
    logic [TW-1:0]     tmr_val;

    pulse_timer #(.TW(TW)) u_timer (
        .clk       (clk),
        .rst       (rst),
        .load_i    (tmr_load),
        .load_val_i(tmr_val),
        .done_o    (tmr_done)
    );

    always_comb begin
        state_d  = state_q;
        tmr_load = 1'b0;
        tmr_val  = '0;
        start    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (trig) begin
                    state_d  = S_HIGH;
                    tmr_load = 1'b1;
                    tmr_val  = HI_LOAD;
                    start    = 1'b1;
                end
            end
            S_HIGH: begin
                if (tmr_done) begin
                    state_d  = S_LOW;
                    tmr_load = 1'b1;
                    tmr_val  = LO_LOAD;
                end
            end
            S_LOW: begin
                // The last low cycle chains straight into the next pulse when work is waiting.
                if (tmr_done) begin
                    if (pending_q != '0 || trig) begin
                        state_d  = S_HIGH;
                        tmr_load = 1'b1;
                        tmr_val  = HI_LOAD;
                        start    = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        inc       = trig && !start;
        dec       = start && !trig;
        pending_d = pending_q;
        drop      = 1'b0;
        if (inc && !dec) begin
            if (pending_q == PEND_MAX) begin
                drop = 1'b1;
            end else begin
                pending_d = pending_q + 1'b1;
            end
        end else if (dec && !inc) begin
            pending_d = pending_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            y_out_q    <= 1'b0;
            busy_q     <= 1'b0;
            pending_q  <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            y_out_q    <= (state_d == S_HIGH);
            busy_q     <= (state_d != S_IDLE);
            pending_q  <= pending_d;
            overflow_q <= overflow_q | drop;
        end
    end

    assign y_out    = y_out_q;
    assign busy     = busy_q;
    assign pending  = pending_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_edge_pulse_gen.sv
// Directed bench for edge_pulse_gen (HIGH=3, LOW=2, PEND_W=2) with a 2-flop
// rising-edge detector model watching y_out.
`include "pulse_defs.vh"

module tb_edge_pulse_gen;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       trig = 1'b0;
    logic       y_out;
    logic       busy;
    logic [1:0] pending;
    logic       overflow;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    int hits  = 0;
    int hits0;
    int peak;
    logic d1 = 1'b0;
    logic d2 = 1'b0;

    edge_pulse_gen #(.HIGH_CYCLES(3), .LOW_CYCLES(2), .PEND_W(2)) dut (
        .clk     (clk),
        .rst     (rst),
        .trig    (trig),
        .y_out   (y_out),
        .busy    (busy),
        .pending (pending),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    // Downstream rising-edge detector
    always @(posedge clk) begin
        d1 <= y_out;
        d2 <= d1;
        if (d1 && !d2) hits <= hits + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s @cyc %0d: observed %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    // Inputs apply to the current cycle; afterwards cyc names the following cycle.
    task automatic tick(input logic t, input logic r);
        trig = t;
        rst  = r;
        @(posedge clk);
        #1;
        trig = 1'b0;
        rst  = 1'b0;
        cyc++;
    endtask

    task automatic do_reset();
        tick(1'b0, 1'b1);
        cyc = 0;
    endtask

    task automatic idle_to(input int n);
        while (cyc < n) tick(1'b0, 1'b0);
    endtask

    initial begin
        // Reset state
        do_reset();
        chk("rst_y", y_out, 0);
        chk("rst_busy", busy, 0);
        chk("rst_pend", pending, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_state", dut.state_q, `ST_IDLE);

        // Test 1: single trig in cycle 10
        idle_to(10);
        hits0 = hits;
        for (int c = 10; c <= 17; c++) begin
            tick(c == 10, 1'b0);
            chk("t1_y", y_out, (cyc >= 11 && cyc <= 13));
            chk("t1_busy", busy, (cyc >= 11 && cyc <= 15));
        end
        idle_to(20);
        chk("t1_hits", hits - hits0, 1);

        // Test 2: trig in 10,11,12 -> rises 11,16,21
        do_reset();
        idle_to(10);
        hits0 = hits;
        peak = 0;
        for (int c = 10; c <= 26; c++) begin
            tick(c <= 12, 1'b0);
            chk("t2_y", y_out, (cyc >= 11 && cyc <= 13) || (cyc >= 16 && cyc <= 18) ||
                               (cyc >= 21 && cyc <= 23));
            if (int'(pending) > peak) peak = int'(pending);
            if (cyc == 16) chk("t2_pend16", pending, 1);
            if (cyc == 21) chk("t2_pend21", pending, 0);
        end
        chk("t2_busy26", busy, 0);
        chk("t2_peak", peak, 2);
        chk("t2_ovf", overflow, 0);
        idle_to(30);
        chk("t2_hits", hits - hits0, 3);

        // Test 3: trig in 10 and in 15 (last low cycle) -> rises 11 and 16, no idle gap
        do_reset();
        idle_to(10);
        hits0 = hits;
        for (int c = 10; c <= 21; c++) begin
            tick(c == 10 || c == 15, 1'b0);
            chk("t3_y", y_out, (cyc >= 11 && cyc <= 13) || (cyc >= 16 && cyc <= 18));
            chk("t3_busy", busy, (cyc >= 11 && cyc <= 20));
            chk("t3_pend", pending, 0);
        end
        idle_to(25);
        chk("t3_hits", hits - hits0, 2);

        // Test 4: trig held 10..14 -> saturation, one dropped request, 4 pulses
        do_reset();
        idle_to(10);
        hits0 = hits;
        for (int c = 10; c <= 31; c++) begin
            tick(c <= 14, 1'b0);
            chk("t4_y", y_out, (cyc >= 11 && cyc <= 13) || (cyc >= 16 && cyc <= 18) ||
                               (cyc >= 21 && cyc <= 23) || (cyc >= 26 && cyc <= 28));
            chk("t4_busy", busy, (cyc >= 11 && cyc <= 30));
            if (cyc == 14) chk("t4_pend_sat", pending, 3);
            if (cyc == 14) chk("t4_ovf14", overflow, 0);
            if (cyc == 15) chk("t4_ovf15", overflow, 1);
        end
        idle_to(36);
        chk("t4_hits", hits - hits0, 4);
        chk("t4_ovf_sticky", overflow, 1);

        // Test 5: rst in cycle 12 during HIGH with pending=2 (overflow still set from test 4)
        cyc = 0;
        idle_to(9);
        hits0 = hits;
        for (int c = 9; c <= 11; c++) tick(1'b1, 1'b0);
        chk("t5_pend12", pending, 2);
        chk("t5_y12", y_out, 1);
        chk("t5_ovf12", overflow, 1);
        tick(1'b0, 1'b1);
        chk("t5_y13", y_out, 0);
        chk("t5_busy13", busy, 0);
        chk("t5_pend13", pending, 0);
        chk("t5_ovf13", overflow, 0);
        for (int c = 13; c <= 24; c++) begin
            tick(1'b0, 1'b0);
            chk("t5_quiet", {busy, y_out}, 2'b00);
        end
        chk("t5_hits", hits - hits0, 1);

        // Test 6: trig together with rst is ignored; trig next cycle works normally
        do_reset();
        idle_to(10);
        hits0 = hits;
        tick(1'b1, 1'b1);
        chk("t6_y11", y_out, 0);
        chk("t6_busy11", busy, 0);
        chk("t6_pend11", pending, 0);
        for (int c = 11; c <= 18; c++) begin
            tick(c == 11, 1'b0);
            chk("t6_y", y_out, (cyc >= 12 && cyc <= 14));
            chk("t6_busy", busy, (cyc >= 12 && cyc <= 16));
        end
        idle_to(22);
        chk("t6_hits", hits - hits0, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
